// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg: shared types and constants for the datapath control sequencer.
// Holds the instruction field layout, opcode/state/class enums and ULA control codes.
package datapath_ctrl_pkg;

    localparam int INSTR_W = 24;

    localparam int OP_HI  = 23;
    localparam int OP_LO  = 20;
    localparam int RD_HI  = 19;
    localparam int RD_LO  = 17;
    localparam int RS1_HI = 16;
    localparam int RS1_LO = 14;
    localparam int RS2_HI = 13;
    localparam int RS2_LO = 11;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_SLT  = 4'h5,
        OP_ADDI = 4'h6,
        OP_SUBI = 4'h7,
        OP_ANDI = 4'h8,
        OP_ORI  = 4'h9,
        OP_SLTI = 4'hA,
        OP_LI   = 4'hB,
        OP_BEQZ = 4'hC,
        OP_JMP  = 4'hD,
        OP_ILL  = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LI,
        CLS_BRANCH,
        CLS_JMP,
        CLS_HALT,
        CLS_ILLEGAL
    } class_t;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_AND = 3'b010;
    localparam logic [2:0] ULA_OR  = 3'b011;
    localparam logic [2:0] ULA_SLT = 3'b101;

    // Register and immediate forms of an operation share one ULA code.
    function automatic logic [2:0] ula_of(input opcode_t op);
        logic [2:0] code;
        case (op)
            OP_SUB, OP_SUBI: code = ULA_SUB;
            OP_AND, OP_ANDI: code = ULA_AND;
            OP_OR,  OP_ORI:  code = ULA_OR;
            OP_SLT, OP_SLTI: code = ULA_SLT;
            default:         code = ULA_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/datapath_ctrl_decode.sv
// datapath_ctrl_decode: combinational instruction decoder.
// Splits the latched instruction into register addresses, ULA controls and an
// execution class. Macro DATAPATH_CTRL_BRANCH_EN enables BEQZ/JMP; without it
// both opcodes decode as illegal.
module datapath_ctrl_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic [2:0]         ra1,
    output logic [2:0]         ra2,
    output logic [2:0]         rd,
    output logic [2:0]         ula_control,
    output logic               select_src,
    output logic [7:0]         constante,
    output class_t             cls
);

    opcode_t opcode;
    logic    unused_bits;

    // Bits [10:8] carry no meaning in this instruction format.
    assign unused_bits = ^ir[10:8];

    // Field extraction and opcode classification.
    always_comb begin
        opcode      = opcode_t'(ir[OP_HI:OP_LO]);
        ra1         = ir[RS1_HI:RS1_LO];
        ra2         = ir[RS2_HI:RS2_LO];
        rd          = ir[RD_HI:RD_LO];
        ula_control = ULA_ADD;
        select_src  = 1'b0;
        constante   = '0;
        cls         = CLS_ILLEGAL;
        case (opcode)
            OP_NOP: cls = CLS_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                cls         = CLS_ALU;
                ula_control = ula_of(opcode);
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI: begin
                cls         = CLS_ALU;
                ula_control = ula_of(opcode);
                select_src  = 1'b1;
                constante   = ir[IMM_HI:IMM_LO];
            end
            OP_LI: cls = CLS_LI;
`ifdef DATAPATH_CTRL_BRANCH_EN
            OP_BEQZ: cls = CLS_BRANCH;
            OP_JMP:  cls = CLS_JMP;
`else
            OP_BEQZ, OP_JMP: cls = CLS_ILLEGAL;
`endif
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle fetch/decode/execute/writeback sequencer driving
// the 8-bit register-file/ULA datapath. Macro DATAPATH_CTRL_BRANCH_EN enables
// BEQZ/JMP; the default build treats them as illegal and always steps PC by one.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int PC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic [7:0]         ULAResult,
    input  logic               Z,
    output logic [2:0]         ra1,
    output logic [2:0]         ra2,
    output logic [2:0]         wa3,
    output logic               we3,
    output logic [7:0]         wd3,
    output logic [2:0]         ULAControl,
    output logic               select_src,
    output logic [7:0]         constante,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);

    state_t              state;
    state_t              state_next;
    logic [PC_W-1:0]     pc;
    logic                zf;
    logic [INSTR_W-1:0]  ir;
    logic [7:0]          res;
    logic [2:0]          rd;
    class_t              cls;

    // Datapath controls come straight from the latched IR, so they stay stable
    // from EXEC through WB and read as zero after reset.
    datapath_ctrl_decode u_decode (
        .ir          (ir),
        .ra1         (ra1),
        .ra2         (ra2),
        .rd          (rd),
        .ula_control (ULAControl),
        .select_src  (select_src),
        .constante   (constante),
        .cls         (cls)
    );

    assign imem_addr = pc;
    assign wa3       = rd;
    assign wd3       = res;

    // State register; reset aborts any instruction, including a WB write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; HALT is spotted on the raw memory word in DECODE.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        halted     = 1'b0;
        we3        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                busy       = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                busy = 1'b1;
                if (imem_data[OP_HI:OP_LO] == OP_HALT) state_next = S_HALT;
                else                                   state_next = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (cls == CLS_ALU || cls == CLS_LI) state_next = S_WB;
                else                                 state_next = S_FETCH;
            end
            S_WB: begin
                busy       = 1'b1;
                we3        = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // PC, instruction, result, zero flag and sticky illegal bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= '0;
            zf      <= 1'b0;
            ir      <= '0;
            res     <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc      <= '0;
                        zf      <= 1'b0;
                        illegal <= 1'b0;
                    end
                end
                S_DECODE: ir <= imem_data;
                S_EXEC: begin
                    pc <= pc + PC_W'(1);
                    case (cls)
                        CLS_ALU: begin
                            res <= ULAResult;
                            zf  <= Z;
                        end
                        CLS_LI:      res <= ir[IMM_HI:IMM_LO];
                        CLS_BRANCH:  if (zf) pc <= ir[IMM_LO +: PC_W];
                        CLS_JMP:     pc <= ir[IMM_LO +: PC_W];
                        CLS_ILLEGAL: illegal <= 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed programs run through a behavioural register-file/ULA
// and a synchronous instruction memory; expected writebacks go into a scoreboard
// that a negedge monitor drains whenever we3 is high.
module tb_datapath_ctrl;

    localparam int PC_W = 6;

    localparam logic [3:0] NOP  = 4'h0;
    localparam logic [3:0] ADD  = 4'h1;
    localparam logic [3:0] SUB  = 4'h2;
    localparam logic [3:0] SLTI = 4'hA;
    localparam logic [3:0] LI   = 4'hB;
    localparam logic [3:0] BEQZ = 4'hC;
    localparam logic [3:0] JMP  = 4'hD;
    localparam logic [3:0] ILL  = 4'hE;
    localparam logic [3:0] HALT = 4'hF;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic [23:0]     imem_data;
    logic [7:0]      ULAResult;
    logic            Z;
    logic [2:0]      ra1, ra2, wa3;
    logic            we3;
    logic [7:0]      wd3;
    logic [2:0]      ULAControl;
    logic            select_src;
    logic [7:0]      constante;
    logic            busy, halted, illegal;

    typedef struct {
        logic [2:0] wa;
        logic [7:0] wd;
        logic       chk;
        logic [2:0] ctl;
        logic       src;
        logic [7:0] cst;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    logic [23:0] mem [64];
    logic [7:0]  regs [8];
    logic [7:0]  op_a, op_b;

    datapath_ctrl #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .ULAResult  (ULAResult),
        .Z          (Z),
        .ra1        (ra1),
        .ra2        (ra2),
        .wa3        (wa3),
        .we3        (we3),
        .wd3        (wd3),
        .ULAControl (ULAControl),
        .select_src (select_src),
        .constante  (constante),
        .busy       (busy),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Behavioural ULA fed by the register file or the immediate.
    always_comb begin
        op_a = regs[ra1];
        op_b = select_src ? constante : regs[ra2];
        case (ULAControl)
            3'b000:  ULAResult = op_a + op_b;
            3'b001:  ULAResult = op_a - op_b;
            3'b010:  ULAResult = op_a & op_b;
            3'b011:  ULAResult = op_a | op_b;
            3'b101:  ULAResult = ($signed(op_a) < $signed(op_b)) ? 8'd1 : 8'd0;
            default: ULAResult = 8'd0;
        endcase
        Z = (ULAResult == 8'd0);
    end

    // Register file write port.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
        end else if (we3) begin
            regs[wa3] <= wd3;
        end
    end

    // Synchronous instruction memory.
    always @(posedge clk) imem_data <= mem[imem_addr];

    function automatic logic [23:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic [7:0] imm);
        return {op, rd, rs1, rs2, 3'b000, imm};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic pushWrite(input logic [2:0] wa, input logic [7:0] wd);
        exp_t e;
        e.wa = wa; e.wd = wd; e.chk = 1'b0; e.ctl = 3'b000; e.src = 1'b0; e.cst = 8'd0;
        sb.push_back(e);
    endtask

    task automatic pushAlu(input logic [2:0] wa, input logic [7:0] wd, input logic [2:0] ctl,
                           input logic src, input logic [7:0] cst);
        exp_t e;
        e.wa = wa; e.wd = wd; e.chk = 1'b1; e.ctl = ctl; e.src = src; e.cst = cst;
        sb.push_back(e);
    endtask

    // Writeback monitor: every we3 cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (we3 === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_write: got wa3=%0d wd3=%0h, want no write", wa3, wd3);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("wb_addr_data", {wa3, wd3}, {mon_e.wa, mon_e.wd});
                if (mon_e.chk) begin
                    checkOutput("wb_ula_ctl", {ULAControl, select_src}, {mon_e.ctl, mon_e.src});
                    if (mon_e.src) checkOutput("wb_constante", constante, mon_e.cst);
                end
            end
        end
    end

    task automatic doReset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 64; i++) mem[i] = 24'd0;
    endtask

    // Pulse start for one edge; the sequencer must be fetching address 0 right after.
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("fetch_addr0", {busy, imem_addr}, {1'b1, 6'd0});
    endtask

    task automatic waitHalted(input int expected, input string name);
        int cnt;
        cnt = 0;
        while (halted !== 1'b1 && cnt < 600) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput(name, cnt, expected);
        checkOutput({name, "_status"}, {halted, busy}, 2'b10);
        @(negedge clk);
        #1;
        checkOutput({name, "_drain"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        clearMem();
        doReset();
        checkOutput("reset_ctl", {ra1, ra2, wa3, we3, ULAControl, select_src, busy, halted, illegal}, 0);
        checkOutput("reset_data", {imem_addr, wd3, constante}, 0);

        // LI/LI/ADD/SUB then BEQZ on zf=1
        $display("[TB] program A: arithmetic and taken BEQZ");
        mem[0]  = enc(LI, 3'd1, 3'd0, 3'd0, 8'd2);
        mem[1]  = enc(LI, 3'd2, 3'd0, 3'd0, 8'd2);
        mem[2]  = enc(ADD, 3'd3, 3'd1, 3'd2, 8'd0);
        mem[3]  = enc(SUB, 3'd4, 3'd1, 3'd2, 8'd0);
        mem[4]  = enc(BEQZ, 3'd0, 3'd0, 3'd0, 8'h10);
        mem[5]  = enc(LI, 3'd7, 3'd0, 3'd0, 8'h55);
        mem[6]  = enc(HALT, 3'd0, 3'd0, 3'd0, 8'd0);
        mem[16] = enc(LI, 3'd7, 3'd0, 3'd0, 8'hAA);
        mem[17] = enc(HALT, 3'd0, 3'd0, 3'd0, 8'd0);
        pushWrite(3'd1, 8'd2);
        pushWrite(3'd2, 8'd2);
        pushAlu(3'd3, 8'd4, 3'b000, 1'b0, 8'd0);
        pushAlu(3'd4, 8'd0, 3'b001, 1'b0, 8'd0);
`ifdef DATAPATH_CTRL_BRANCH_EN
        pushWrite(3'd7, 8'hAA);
`else
        pushWrite(3'd7, 8'h55);
`endif
        applyStimulus();
        waitHalted(25, "progA_cycles");
`ifdef DATAPATH_CTRL_BRANCH_EN
        checkOutput("progA_illegal", illegal, 1'b0);
`else
        checkOutput("progA_illegal", illegal, 1'b1);
`endif

        // BEQZ not taken: zf=0 from SUB although live Z is 1 during BEQZ
        $display("[TB] program B: BEQZ not taken");
        doReset();
        clearMem();
        mem[0]  = enc(LI, 3'd1, 3'd0, 3'd0, 8'd2);
        mem[1]  = enc(LI, 3'd2, 3'd0, 3'd0, 8'd3);
        mem[2]  = enc(SUB, 3'd4, 3'd1, 3'd2, 8'd0);
        mem[3]  = enc(BEQZ, 3'd0, 3'd0, 3'd0, 8'h10);
        mem[4]  = enc(LI, 3'd7, 3'd0, 3'd0, 8'h55);
        mem[5]  = enc(HALT, 3'd0, 3'd0, 3'd0, 8'd0);
        mem[16] = enc(LI, 3'd7, 3'd0, 3'd0, 8'hAA);
        mem[17] = enc(HALT, 3'd0, 3'd0, 3'd0, 8'd0);
        pushWrite(3'd1, 8'd2);
        pushWrite(3'd2, 8'd3);
        pushAlu(3'd4, 8'hFF, 3'b001, 1'b0, 8'd0);
        pushWrite(3'd7, 8'h55);
        applyStimulus();
        waitHalted(21, "progB_cycles");

        // SLTI with immediate operand
        $display("[TB] program C: SLTI");
        doReset();
        clearMem();
        mem[0] = enc(LI, 3'd1, 3'd0, 3'd0, 8'd3);
        mem[1] = enc(SLTI, 3'd5, 3'd1, 3'd0, 8'd12);
        mem[2] = enc(HALT, 3'd0, 3'd0, 3'd0, 8'd0);
        pushWrite(3'd1, 8'd3);
        pushAlu(3'd5, 8'd1, 3'b101, 1'b1, 8'd12);
        applyStimulus();
        waitHalted(10, "progC_cycles");

        // PC wrap from 63 to 0, then halt and restart
        $display("[TB] program D: PC wrap and restart");
        doReset();
        clearMem();
        mem[63] = enc(LI, 3'd6, 3'd0, 3'd0, 8'h3F);
        pushWrite(3'd6, 8'h3F);
        pushWrite(3'd5, 8'h5A);
        applyStimulus();
        cnt = 0;
        while (!(we3 === 1'b1 && wa3 == 3'd6) && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput("wrap_reach_cycles", cnt, 192);
        checkOutput("wrap_next_addr", imem_addr, 6'd0);
        mem[0] = enc(LI, 3'd5, 3'd0, 3'd0, 8'h5A);
        mem[1] = enc(HALT, 3'd0, 3'd0, 3'd0, 8'd0);
        waitHalted(7, "wrap_halt_cycles");
        pushWrite(3'd5, 8'h5A);
        applyStimulus();
        waitHalted(6, "restart_cycles");

        // Reset during ADD writeback
        $display("[TB] program E: reset during WB");
        doReset();
        clearMem();
        mem[0] = enc(LI, 3'd1, 3'd0, 3'd0, 8'd2);
        mem[1] = enc(LI, 3'd2, 3'd0, 3'd0, 8'd2);
        mem[2] = enc(ADD, 3'd3, 3'd1, 3'd2, 8'd0);
        mem[3] = enc(HALT, 3'd0, 3'd0, 3'd0, 8'd0);
        pushWrite(3'd1, 8'd2);
        pushWrite(3'd2, 8'd2);
        applyStimulus();
        cnt = 0;
        while (!(we3 === 1'b1 && wa3 == 3'd3) && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput("add_wb_cycles", cnt, 11);
        checkOutput("add_wd3", wd3, 8'd4);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_wb_ctl", {ra1, ra2, wa3, we3, ULAControl, select_src, busy, halted, illegal}, 0);
        checkOutput("rst_wb_data", {imem_addr, wd3, constante}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_after_rst", {busy, halted, we3}, 3'b000);
        checkOutput("rst_drain", sb.size(), 0);

        // Opcode E, then JMP restarted from HALT
        $display("[TB] program F: illegal opcode and JMP");
        doReset();
        clearMem();
        mem[0] = enc(ILL, 3'd1, 3'd0, 3'd0, 8'd9);
        mem[1] = enc(HALT, 3'd0, 3'd0, 3'd0, 8'd0);
        applyStimulus();
        waitHalted(5, "illE_cycles");
        checkOutput("illE_flag", illegal, 1'b1);
        clearMem();
        mem[0] = enc(JMP, 3'd0, 3'd0, 3'd0, 8'd5);
        mem[1] = enc(LI, 3'd1, 3'd0, 3'd0, 8'h11);
        mem[2] = enc(HALT, 3'd0, 3'd0, 3'd0, 8'd0);
        mem[5] = enc(LI, 3'd1, 3'd0, 3'd0, 8'h22);
        mem[6] = enc(HALT, 3'd0, 3'd0, 3'd0, 8'd0);
`ifdef DATAPATH_CTRL_BRANCH_EN
        pushWrite(3'd1, 8'h22);
`else
        pushWrite(3'd1, 8'h11);
`endif
        applyStimulus();
        checkOutput("illegal_cleared", illegal, 1'b0);
        waitHalted(9, "jmp_cycles");
`ifdef DATAPATH_CTRL_BRANCH_EN
        checkOutput("jmp_illegal", illegal, 1'b0);
`else
        checkOutput("jmp_illegal", illegal, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Multi-cycle control sequencer that sits directly upstream of the 8-bit register-file/ULA datapath. It fetches 24-bit instructions from a synchronous instruction memory, decodes them, and drives the datapath's register addresses, ULA control, source select and constant. It writes ULAResult (or an immediate) back through wd3/wa3/we3 and resolves branches on a latched Z flag.

## Interface
- PC_W, 6, program-counter / instruction-memory address width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begins execution at PC 0 when idle or halted
- imem_addr  out  PC_W  instruction address (= PC)
- imem_data  in  24  instruction word, valid 1 cycle after imem_addr
- ULAResult  in  8  datapath ULA result
- Z  in  1  datapath zero flag
- ra1, ra2  out  3  register-file read addresses
- wa3  out  3  register-file write address
- we3  out  1  register-file write enable
- wd3  out  8  register-file write data
- ULAControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- select_src  out  1  0 = rs2 operand, 1 = constante
- constante  out  8  immediate operand
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- halted  out  1  high in HALT
- illegal  out  1  sticky, set on undefined opcode, cleared by rst or start

## Operation
- Fields: opcode[23:20], rd[19:17], rs1[16:14], rs2[13:11], [10:8] ignored, imm[7:0].
- Opcodes: 0 NOP; 1–5 ADD/SUB/AND/OR/SLT (select_src=0); 6–A ADDI/SUBI/ANDI/ORI/SLTI (select_src=1, constante=imm); B LI (wd3=imm, no ULA); C BEQZ (PC←imm[PC_W-1:0] if zf=1); D JMP (PC←imm[PC_W-1:0]); F HALT; E illegal (NOP + set illegal).
- States: IDLE→(start)→FETCH→DECODE→EXEC→WB→FETCH; NOP/BEQZ/JMP/illegal go EXEC→FETCH; HALT goes DECODE→HALT; HALT→(start)→FETCH with PC=0, zf=0.
- FETCH: imem_addr=PC. DECODE: IR←imem_data; ra1/ra2/ULAControl/select_src/constante registered from IR, held through WB.
- EXEC: ALU ops latch res←ULAResult, zf←Z; LI latches res←imm, zf unchanged. Sequential next PC = PC+1 mod 2^PC_W; taken branch overrides.
- WB: we3=1, wa3=rd, wd3=res, exactly one cycle. Writes to any rd 0–7 allowed.
- start ignored while busy. Arithmetic is 8-bit, carries discarded (ULA's own).

## Timing
- Reset: state IDLE, PC 0, zf 0, IR 0; all outputs 0 (we3, busy, halted, illegal = 0).
- rst mid-instruction: immediate async return to IDLE; an in-progress WB write is aborted (we3 falls with rst).
- Latency: ALU/LI 4 cycles, NOP/branch/illegal 3 cycles, HALT 2 cycles to halted=1.
- start sampled high in IDLE: FETCH next cycle, imem_addr=0.
- PC wrap: instruction at 2^PC_W-1 followed by fetch at 0.
- BEQZ uses zf from the most recent ALU instruction, never the live Z.

## Configuration
- DATAPATH_CTRL_BRANCH_EN defined: opcodes C/D execute as above.
- Undefined: C/D treated as illegal (NOP, illegal set); PC always increments; zf still updated.

## Structure
- Package datapath_ctrl_pkg: opcode enum, state enum, ULAControl constants, field bit positions, INSTR_W=24.
- Sub-module datapath_ctrl_decode: combinational IR→{ra1, ra2, rd, ULAControl, select_src, constante, class (alu/li/branch/jmp/halt/nop/illegal)}; FSM, PC and result registers in datapath_ctrl.

## Test plan
- LI r1,2; LI r2,2; ADD r3,r1,r2 against real datapath -> WB cycles write 2, 2, 4 to wa3 1, 2, 3; ADD WB 4 cycles after its fetch.
- SUB r4,r1,r2 then BEQZ 0x10 -> zf=1, next imem_addr=0x10; with r2=3 branch not taken, imem_addr=PC+1.
- SLTI r5,r1,12 (r1=3) -> select_src=1, constante=12, ULAControl=101, wd3=1 in WB.
- Program at 63 without branch -> next fetch address 0; HALT -> halted=1, busy=0, start restarts at 0.
- rst asserted during WB of ADD -> we3 drops same time, all outputs 0, IDLE.
- Opcode E -> illegal=1, no write; without DATAPATH_CTRL_BRANCH_EN, JMP 5 -> illegal=1, PC+1.
